keccak_arbiter: RTL
===================

KECCAK_ARBITER -- requirements
Module: keccak_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning the number of requesters sharing one keccak core (range 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, NUM_REQ, meaning requester i has a word on its lane.
REQ-005 SHALL have port req_data, input, 32*NUM_REQ, meaning the message word for lane i at bits [32i+31:32i].
REQ-006 SHALL have port req_last, input, NUM_REQ, meaning the lane-i word is the final word of its message.
REQ-007 SHALL have port req_bytes, input, 2*NUM_REQ, meaning the valid byte count of the final word (0 = empty trailing word), per the core byte_num encoding.
REQ-008 SHALL have port req_ready, output, NUM_REQ, meaning lane i's word is accepted this cycle when req_ready and req_valid are both high.
REQ-009 SHALL have core-side ports core_reset, core_in[31:0], core_in_ready, core_is_last and core_byte_num[1:0], all outputs, driving the keccak core.
REQ-010 SHALL have core-side ports core_buffer_full (1), core_out (512) and core_out_ready (1), all inputs, sampled from the keccak core.
REQ-011 SHALL have port dig_valid, output, 1, a one-cycle pulse that marks the digest as valid.
REQ-012 SHALL have port dig_data, output, 512, the registered digest.
REQ-013 SHALL have port dig_id, output, clog2(NUM_REQ), the requester that owns dig_data.

Function
REQ-014 SHALL implement the states IDLE, CLR, FEED, WAIT and DONE.
REQ-015 SHALL leave IDLE for CLR on the first edge where any req_valid is high, latching the grant as the round-robin winner searched from (last_grant+1) mod NUM_REQ.
REQ-016 SHALL assert core_reset for exactly one cycle while in CLR, then go to FEED.
REQ-017 SHALL, in FEED, drive req_ready[g] = !core_buffer_full for granted lane g, and drive all other req_ready bits low.
REQ-018 SHALL, in FEED, drive core_in_ready = req_valid[g] & req_ready[g] combinationally, with core_in, core_is_last and core_byte_num taken from lane g in the same cycle.
REQ-019 SHALL go from FEED to WAIT on an accepted word with req_last[g] high; a lane that deasserts valid mid-message stalls FEED indefinitely, with no timeout.
REQ-020 SHALL, in WAIT, hold all req_ready low and core_in_ready low, and go to DONE on the first cycle core_out_ready is high.
REQ-021 SHALL capture core_out into dig_data and g into dig_id on the WAIT-to-DONE edge.
REQ-022 SHALL assert dig_valid for the single DONE cycle, set last_grant = g, then return to IDLE.
REQ-023 SHALL hold dig_data and dig_id after DONE until the next capture.
REQ-024 SHALL have a minimum latency from req_valid in IDLE to the first accepted word of 2 cycles.
REQ-025 SHALL never preempt a granted message; other lanes' requests arriving during CLR/FEED/WAIT/DONE are arbitrated only in IDLE.

Reset
REQ-026 SHALL, while reset is high, set state = IDLE, last_grant = NUM_REQ-1 (so lane 0 wins first), dig_valid = 0, dig_data = 0, dig_id = 0, req_ready = 0, core_in_ready = 0 and core_reset = 1.
REQ-027 SHALL, when reset is asserted mid-message, abandon the message, emit no digest, and make the abandoned requester re-request from IDLE.

Configuration
REQ-028 SHALL, with KECCAK_ARB_STATS_EN defined, add output msg_count[15:0] that counts DONE cycles, wraps at 0xFFFF to 0, and is cleared by reset.
REQ-029 SHALL, without KECCAK_ARB_STATS_EN, omit the port and the counter, with otherwise identical behaviour.

Structure
REQ-030 SHALL place the state enum, WORD_W=32, DIGEST_W=512 and BYTES_W=2 in package keccak_arb_pkg.
REQ-031 SHALL implement round-robin selection in sub-module rr_arbiter (inputs req and last_grant; output grant index and any_req).

Verification
REQ-032 SHALL cover: lane 0 sends "Hell","o, w","orld","!   " with req_bytes=1 -> one core_reset pulse; dig_id=0; dig_data equals a standalone core run of "Hello, world!".
REQ-033 SHALL cover: lanes 0 and 1 valid in the same IDLE cycle after reset -> lane 0 served first, lane 1 next; dig_id sequence is 0, 1.
REQ-034 SHALL cover: lane 1 sends a 4-word message, then lanes 0 and 1 both request -> lane 0 granted (round-robin from 1+1).
REQ-035 SHALL cover: core_buffer_full forced high for 10 cycles during FEED -> req_ready low throughout, no words lost or duplicated, digest unchanged.
REQ-036 SHALL cover: reset pulsed after 5 accepted words -> no dig_valid, state IDLE, next message's digest is correct.
REQ-037 SHALL cover, with KECCAK_ARB_STATS_EN: 3 messages -> msg_count=3; preload to 0xFFFF, then one more message -> msg_count=0.

Source files
------------

// File: rtl/keccak_arb_pkg.sv
// Shared types and widths for the keccak requester arbiter.
`default_nettype none

package keccak_arb_pkg;

  localparam int WORD_W   = 32;
  localparam int DIGEST_W = 512;
  localparam int BYTES_W  = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    FEED = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// Round-robin lane selector: searches from (last_grant+1) mod NUM_REQ upward.
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       any_req
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        grant = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/keccak_arbiter.sv
// Shares one keccak core among NUM_REQ message requesters, one whole message at a time.
// Optional KECCAK_ARB_STATS_EN adds a 16-bit completed-message counter output.
`default_nettype none

module keccak_arbiter
  import keccak_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [WORD_W*NUM_REQ-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [BYTES_W*NUM_REQ-1:0]   req_bytes,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         core_reset,
  output logic [WORD_W-1:0]            core_in,
  output logic                         core_in_ready,
  output logic                         core_is_last,
  output logic [BYTES_W-1:0]           core_byte_num,
  input  logic                         core_buffer_full,
  input  logic [DIGEST_W-1:0]          core_out,
  input  logic                         core_out_ready,
  output logic                         dig_valid,
  output logic [DIGEST_W-1:0]          dig_data,
  output logic [$clog2(NUM_REQ)-1:0]   dig_id
`ifdef KECCAK_ARB_STATS_EN
  ,
  output logic [15:0]                  msg_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [DIGEST_W-1:0] dig_data_q;
  logic [IDX_W-1:0]    dig_id_q;
  logic [IDX_W-1:0]    rr_grant;
  logic                any_req;
  logic                accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (rr_grant),
    .any_req    (any_req)
  );

  assign accept = (state_q == FEED) && req_valid[grant_q] && !core_buffer_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = CLR;
        grant_d = rr_grant;
      end
      CLR:  state_d = FEED;
      FEED: if (accept && req_last[grant_q]) state_d = WAIT;
      WAIT: if (core_out_ready) state_d = DONE;
      DONE: begin
        state_d      = IDLE;
        last_grant_d = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane mux is unconditional; core_in_ready alone qualifies the word.
  always_comb begin
    req_ready               = '0;
    req_ready[grant_q]      = (state_q == FEED) && !core_buffer_full;
    core_in_ready           = accept;
    core_in                 = req_data[int'(grant_q)*WORD_W +: WORD_W];
    core_is_last            = req_last[grant_q];
    core_byte_num           = req_bytes[int'(grant_q)*BYTES_W +: BYTES_W];
    core_reset              = reset || (state_q == CLR);
    dig_valid               = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig_data_q <= '0;
      dig_id_q   <= '0;
    end else if (state_q == WAIT && core_out_ready) begin
      dig_data_q <= core_out;
      dig_id_q   <= grant_q;
    end
  end

  assign dig_data = dig_data_q;
  assign dig_id   = dig_id_q;

`ifdef KECCAK_ARB_STATS_EN
  logic [15:0] msg_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_count_q <= '0;
    end else if (state_q == DONE) begin
      msg_count_q <= msg_count_q + 16'd1;
    end
  end

  assign msg_count = msg_count_q;
`endif

endmodule

`default_nettype wire
